// File: rtl/t09_snake_pkg.sv
// Shared snake-game constants: grid defaults, coordinate widths and placement FSM state codes.
package t09_snake_pkg;

  localparam int GRID_W_DEF = 14;
  localparam int GRID_H_DEF = 10;
  localparam int XW_DEF     = 4;
  localparam int YW_DEF     = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_SCAN   = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_RETRY  = 3'd4;

  function automatic int abs_diff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/t09_obstacle_manager_if.sv
// Game-side bus of the obstacle manager: spawn control, body snapshot, lookup port and status.
interface t09_obstacle_manager_if
  import t09_snake_pkg::*;
#(
  parameter int XW         = XW_DEF,
  parameter int YW         = YW_DEF,
  parameter int MAX_LENGTH = 50,
  parameter int CW         = 4
) ();

  logic                         s_reset;
  logic                         enable;
  logic                         goodColl;
  logic [XW-1:0]                randX;
  logic [YW-1:0]                randY;
  logic [MAX_LENGTH*(XW+YW)-1:0] body;
  logic [7:0]                   curr_length;
  logic [XW-1:0]                x;
  logic [YW-1:0]                y;
  logic                         obstacle;
  logic [CW-1:0]                obstacleCount;
  logic                         busy;
  logic                         spawn_done;
  logic                         spawn_fail;

  modport master (
    output s_reset, enable, goodColl, randX, randY, body, curr_length, x, y,
    input  obstacle, obstacleCount, busy, spawn_done, spawn_fail
  );

  modport slave (
    input  s_reset, enable, goodColl, randX, randY, body, curr_length, x, y,
    output obstacle, obstacleCount, busy, spawn_done, spawn_fail
  );

endinterface

// File: rtl/t09_cell_index.sv
// Maps a grid coordinate to its flat occupancy-map index; coordinate 0 or beyond the grid is out of range.
module t09_cell_index
  import t09_snake_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int XW     = XW_DEF,
  parameter int YW     = YW_DEF,
  parameter int IW     = $clog2(GRID_W * GRID_H)
) (
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output logic          in_range_o,
  output logic [IW-1:0] idx_o
);

  assign in_range_o = (x_i != '0) && (int'(x_i) <= GRID_W) &&
                      (y_i != '0) && (int'(y_i) <= GRID_H);
  assign idx_o      = IW'((int'(y_i) - 1) * GRID_W + int'(x_i) - 1);

endmodule

// File: rtl/t09_obstacle_manager.sv
// Obstacle spawner: counts apples, places validated random obstacles into a flat occupancy map
// and answers combinational map lookups for the pixel/collision path.
module t09_obstacle_manager
  import t09_snake_pkg::*;
#(
  parameter int GRID_W      = GRID_W_DEF,
  parameter int GRID_H      = GRID_H_DEF,
  parameter int XW          = XW_DEF,
  parameter int YW          = YW_DEF,
  parameter int MAX_LENGTH  = 50,
  parameter int MAX_OBS     = 15,
  parameter int CW          = 4,
  parameter int SPAWN_EVERY = 1,
  parameter int MAX_TRIES   = 8
) (
  input  logic                  clk,
  input  logic                  nRst,
  t09_obstacle_manager_if.slave bus
);

  localparam int SEGW  = XW + YW;
  localparam int CELLS = GRID_W * GRID_H;
  localparam int IW    = $clog2(CELLS);
  localparam int AW    = (SPAWN_EVERY > 1) ? $clog2(SPAWN_EVERY) : 1;
  localparam int TW    = $clog2(MAX_TRIES + 1);

  logic [CELLS-1:0] map_q, map_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    apple_q, apple_d;
  logic             pending_q, pending_d;
  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [7:0]       idx_q, idx_d;
  logic             done_q, done_d, fail_q, fail_d;
  logic [XW-1:0]    cand_x_q, cand_x_d;
  logic [YW-1:0]    cand_y_q, cand_y_d;

  logic [XW-1:0]   cx;
  logic [YW-1:0]   cy;
  logic            cand_ok, look_ok, near_head, near_obs, seg_hit, dens_ok, req;
  logic [IW-1:0]   cand_idx, look_idx;
  logic [SEGW-1:0] seg;

  // While sampling, validate the live random value; afterwards the latched candidate
  assign cx = (state_q == ST_SAMPLE) ? bus.randX : cand_x_q;
  assign cy = (state_q == ST_SAMPLE) ? bus.randY : cand_y_q;

  t09_cell_index #(.GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW), .IW(IW)) u_cand (
    .x_i(cx), .y_i(cy), .in_range_o(cand_ok), .idx_o(cand_idx)
  );

  t09_cell_index #(.GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW), .IW(IW)) u_look (
    .x_i(bus.x), .y_i(bus.y), .in_range_o(look_ok), .idx_o(look_idx)
  );

  assign bus.obstacle      = look_ok && map_q[look_idx];
  assign bus.obstacleCount = count_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.spawn_done    = done_q;
  assign bus.spawn_fail    = fail_q;

  assign near_head = (abs_diff(int'(cx), int'(bus.body[SEGW-1 -: XW])) +
                      abs_diff(int'(cy), int'(bus.body[YW-1:0]))) == 1;

  // Keep a one-cell gap between obstacles: any set cell in the 3x3 window rejects
  always_comb begin
    near_obs = 1'b0;
    for (int i = 0; i < CELLS; i++)
      if (map_q[i] && abs_diff(i % GRID_W + 1, int'(cx)) <= 1 &&
          abs_diff(i / GRID_W + 1, int'(cy)) <= 1)
        near_obs = 1'b1;
  end

  always_comb begin
    seg = '0;
    for (int i = 0; i < MAX_LENGTH; i++)
      if (int'(idx_q) == i) seg = bus.body[i*SEGW +: SEGW];
  end

  assign seg_hit = ({cand_x_q, cand_y_q} == seg);
  assign dens_ok = (bus.curr_length < 8'd3) ||
                   ((9'(count_q) + 9'd1) * 9'd2 < 9'(bus.curr_length) + 9'd2);

  always_comb begin
    map_d     = map_q;
    count_d   = count_q;
    apple_d   = apple_q;
    pending_d = pending_q;
    state_d   = state_q;
    tries_d   = tries_q;
    idx_d     = idx_q;
    cand_x_d  = cand_x_q;
    cand_y_d  = cand_y_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    req       = 1'b0;

    if (bus.goodColl) begin
      if (int'(apple_q) == SPAWN_EVERY - 1) begin
        apple_d = '0;
        req     = 1'b1;
      end else begin
        apple_d = apple_q + AW'(1);
      end
    end
    if (req && state_q != ST_IDLE) pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req || pending_q) begin
          pending_d = 1'b0;
          if (int'(count_q) < MAX_OBS) begin
            state_d = ST_SAMPLE;
            tries_d = '0;
          end
        end
      end
      ST_SAMPLE: begin
        cand_x_d = bus.randX;
        cand_y_d = bus.randY;
        tries_d  = tries_q + TW'(1);
        idx_d    = '0;
        state_d  = (!cand_ok || near_head || near_obs) ? ST_RETRY : ST_SCAN;
      end
      ST_SCAN: begin
        if (bus.curr_length == 8'd0)                state_d = ST_COMMIT;
        else if (seg_hit)                           state_d = ST_RETRY;
        else if (idx_q + 8'd1 >= bus.curr_length)   state_d = ST_COMMIT;
        else                                        idx_d   = idx_q + 8'd1;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (dens_ok) begin
          map_d[cand_idx] = 1'b1;
          count_d         = count_q + CW'(1);
          done_d          = 1'b1;
        end else begin
          fail_d = 1'b1;
        end
      end
      ST_RETRY: begin
        if (int'(tries_q) == MAX_TRIES) begin
          fail_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SAMPLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      map_q     <= '0;
      count_q   <= '0;
      apple_q   <= '0;
      pending_q <= 1'b0;
      state_q   <= ST_IDLE;
      tries_q   <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else if (bus.s_reset || !bus.enable) begin
      map_q     <= '0;
      count_q   <= '0;
      apple_q   <= '0;
      pending_q <= 1'b0;
      state_q   <= ST_IDLE;
      tries_q   <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      map_q     <= map_d;
      count_q   <= count_d;
      apple_q   <= apple_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      tries_q   <= tries_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  always_ff @(posedge clk) begin
    cand_x_q <= cand_x_d;
    cand_y_q <= cand_y_d;
  end

endmodule

// File: tb/tb_t09_obstacle_manager.sv
// Scoreboard bench for the obstacle manager: a rule-level placement model predicts each
// spawn outcome, and a monitor compares it with the spawn_done/spawn_fail pulses.
module tb_t09_obstacle_manager;

  localparam int GW = 14, GH = 10, ML = 50, MAXOBS = 15;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  t09_obstacle_manager_if bus ();
  t09_obstacle_manager dut (.clk(clk), .nRst(nRst), .bus(bus));

  typedef struct {
    bit is_done;
    int count;
    int lat;
    int req_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_fail = 0, cyc = 0;
  bit   mmap[16][16];
  int   mcount;
  int   bx[ML], by[ML];
  int   blen;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit in_grid(int x, int y);
    return x >= 1 && x <= GW && y >= 1 && y <= GH;
  endfunction

  function automatic bit cand_ok(int x, int y);
    if (!in_grid(x, y)) return 1'b0;
    if ((x - bx[0]) * (x - bx[0]) + (y - by[0]) * (y - by[0]) == 1) return 1'b0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if (in_grid(x + dx, y + dy) && mmap[x + dx][y + dy]) return 1'b0;
    for (int i = 0; i < blen; i++)
      if (bx[i] == x && by[i] == y) return 1'b0;
    return 1'b1;
  endfunction

  // First try sees A, every later try sees B; body is static for the request
  function automatic void model_req(int ax, int ay, int bx2, int by2, bit timed, int rc);
    exp_t e;
    int   cx, cy;
    bit   acc;
    if (mcount == MAXOBS) return;
    e.req_cyc = rc;
    e.lat     = -1;
    acc       = 1'b0;
    cx = 0; cy = 0;
    if (cand_ok(ax, ay)) begin
      cx = ax; cy = ay; acc = 1'b1;
      if (timed) e.lat = 2 + ((blen > 1) ? blen : 1);
    end else if (cand_ok(bx2, by2)) begin
      cx = bx2; cy = by2; acc = 1'b1;
    end
    if (acc && (blen < 3 || (mcount + 1) * 2 < blen + 2)) begin
      mmap[cx][cy] = 1'b1;
      mcount++;
      e.is_done = 1'b1;
    end else begin
      e.is_done = 1'b0;
    end
    e.count = mcount;
    sb.push_back(e);
  endfunction

  function automatic void model_clear();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) mmap[x][y] = 1'b0;
    mcount = 0;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.spawn_done || bus.spawn_fail) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got done=%0d fail=%0d, required no pulse",
                 bus.spawn_done, bus.spawn_fail);
      end else begin
        e = sb.pop_front();
        if (bus.spawn_done !== e.is_done || bus.spawn_fail !== !e.is_done ||
            int'(bus.obstacleCount) != e.count) begin
          n_fail++;
          $display("FAIL pulse: got done=%0d fail=%0d count=%0d, required done=%0d fail=%0d count=%0d",
                   bus.spawn_done, bus.spawn_fail, bus.obstacleCount, e.is_done, !e.is_done, e.count);
        end
        if (e.lat >= 0) begin
          n_cmp++;
          if (cyc - e.req_cyc - 1 != e.lat) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, required %0d", cyc - e.req_cyc - 1, e.lat);
          end
        end
      end
    end
  end

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic sweep(string tag);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        bus.x = 4'(x);
        bus.y = 4'(y);
        #1;
        check($sformatf("%s_obs_%0d_%0d", tag, x, y), int'(bus.obstacle),
              (in_grid(x, y) && mmap[x][y]) ? 1 : 0);
      end
  endtask

  task automatic load_body();
    for (int i = 0; i < ML; i++) bus.body[i*8 +: 8] = {4'(bx[i]), 4'(by[i])};
    bus.curr_length = 8'(blen);
  endtask

  task automatic request(int ax, int ay, int bx2, int by2);
    @(negedge clk);
    bus.goodColl = 1'b1;
    bus.randX    = 4'(ax);
    bus.randY    = 4'(ay);
    model_req(ax, ay, bx2, by2, 1'b1, cyc);
    @(negedge clk);
    bus.goodColl = 1'b0;
    @(negedge clk);
    bus.randX = 4'(bx2);
    bus.randY = 4'(by2);
  endtask

  task automatic wait_idle(string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || bus.busy) && n < 400);
    if (sb.size() != 0 || bus.busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got queued=%0d busy=%0d, required 0 and 0", tag, sb.size(), bus.busy);
      sb.delete();
    end
    check({tag, "_count"}, int'(bus.obstacleCount), mcount);
  endtask

  task automatic watch_idle(string tag, int cycles);
    int saw;
    saw = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.busy) saw = 1;
    end
    check({tag, "_busy_seen"}, saw, 0);
  endtask

  task automatic clear_body();
    for (int i = 0; i < ML; i++) begin
      bx[i] = 0;
      by[i] = 0;
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ax, ay, bx2, by2, k, sx, sy;

    // Reset with garbage on every input
    bus.s_reset     = 1'b0;
    bus.enable      = 1'b1;
    bus.goodColl    = 1'b1;
    bus.randX       = 4'd5;
    bus.randY       = 4'd5;
    bus.body        = '1;
    bus.curr_length = 8'hff;
    bus.x           = '0;
    bus.y           = '0;
    model_clear();
    clear_body();
    blen = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_count", int'(bus.obstacleCount), 0);
    check("rst_done", int'(bus.spawn_done), 0);
    check("rst_fail", int'(bus.spawn_fail), 0);
    sweep("rst");
    bus.goodColl = 1'b0;
    @(negedge clk);
    nRst = 1'b1;

    // Clean spawn, body far away
    blen = 4;
    bx[0] = 12; by[0] = 9; bx[1] = 12; by[1] = 8;
    bx[2] = 12; by[2] = 7; bx[3] = 12; by[3] = 6;
    load_body();
    request(5, 5, 5, 5);
    wait_idle("clean");
    sweep("clean");

    // First candidate on body segment 2, second one free
    clear_body();
    bx[0] = 3; by[0] = 4; bx[1] = 3; by[1] = 3;
    bx[2] = 3; by[2] = 2; bx[3] = 3; by[3] = 1;
    load_body();
    request(3, 2, 9, 7);
    wait_idle("retry");
    sweep("retry");

    // Density limit: len 4 with two obstacles
    request(12, 2, 12, 2);
    wait_idle("density");

    // Exhaustion: candidate always next to the head
    request(3, 5, 3, 5);
    wait_idle("exhaust");

    // Restart in the middle of a long scan with a pending request
    clear_body();
    blen = 40;
    load_body();
    @(negedge clk);
    bus.goodColl = 1'b1;
    bus.randX = 4'd10;
    bus.randY = 4'd2;
    @(negedge clk);
    bus.goodColl = 1'b0;
    repeat (3) @(negedge clk);
    bus.goodColl = 1'b1;
    @(negedge clk);
    bus.goodColl = 1'b0;
    bus.s_reset  = 1'b1;
    @(negedge clk);
    bus.s_reset = 1'b0;
    model_clear();
    check("restart_busy", int'(bus.busy), 0);
    check("restart_count", int'(bus.obstacleCount), 0);
    check("restart_done", int'(bus.spawn_done), 0);
    sweep("restart");
    watch_idle("restart", 60);

    // Fill to capacity with short body, then one more request is dropped
    blen = 0;
    load_body();
    k = 0;
    for (int yi = 0; yi < 4; yi++)
      for (int xi = 0; xi < 5; xi++)
        if (k < MAXOBS) begin
          sx = 1 + 3 * xi;
          sy = 1 + 3 * yi;
          request(sx, sy, sx, sy);
          wait_idle("fill");
          k++;
        end
    request(2, 9, 2, 9);
    watch_idle("full", 20);
    check("full_count", int'(bus.obstacleCount), MAXOBS);
    sweep("full");

    // Clear through enable, then a request, a pending one and a dropped third
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
    model_clear();
    check("enable_clear_count", int'(bus.obstacleCount), 0);
    @(negedge clk);
    bus.goodColl = 1'b1;
    bus.randX = 4'd7;
    bus.randY = 4'd4;
    model_req(7, 4, 7, 4, 1'b1, cyc);
    @(negedge clk);
    model_req(7, 4, 7, 4, 1'b0, cyc);
    @(negedge clk);
    @(negedge clk);
    bus.goodColl = 1'b0;
    wait_idle("pending");
    sweep("pending");

    // Randomized requests against the rule model
    @(negedge clk);
    bus.s_reset = 1'b1;
    @(negedge clk);
    bus.s_reset = 1'b0;
    model_clear();
    for (int r = 0; r < 80; r++) begin
      blen = $urandom_range(10, 0);
      for (int i = 0; i < ML; i++) begin
        bx[i] = $urandom_range(15, 0);
        by[i] = $urandom_range(11, 0);
      end
      load_body();
      case ($urandom_range(3, 0))
        0: begin ax = $urandom_range(15, 0); ay = $urandom_range(15, 0); end
        1: begin
          k  = (blen > 0) ? $urandom_range(blen - 1, 0) : 0;
          ax = bx[k];
          ay = by[k];
        end
        2: begin ax = (bx[0] + 1) & 15; ay = by[0]; end
        default: begin ax = $urandom_range(GW, 1); ay = $urandom_range(GH, 1); end
      endcase
      if ($urandom_range(1, 0) == 1) begin
        bx2 = $urandom_range(GW, 1);
        by2 = $urandom_range(GH, 1);
      end else begin
        bx2 = $urandom_range(15, 0);
        by2 = $urandom_range(15, 0);
      end
      request(ax, ay, bx2, by2);
      wait_idle("rand");
    end
    sweep("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
